serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Bit-serial unsigned adder: complement of the combinational half subtractor in
//  the arithmetic set. Takes two WIDTH-bit operands, adds one bit per clock LSB-first
//  through a single full-adder cell and a carry flip-flop, then presents the
//  registered sum and carry-out with a one-cycle done pulse. Used where area
//  matters more than latency.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits (WIDTH >= 2)
// PORTS
//  clk    input   1      single clock, all state on rising edge
//  rst_n  input   1      asynchronous, active-low reset
//  start  input   1      request; sampled only in IDLE
//  a      input   WIDTH  operand A, captured on accepted start
//  b      input   WIDTH  operand B, captured on accepted start
//  busy   output  1      high in RUN and DONE states
//  done   output  1      one-cycle pulse, result valid
//  sum    output  WIDTH  registered result (a+b) mod 2^WIDTH
//  cout   output  1      registered carry-out of MSB
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy=0, done=0, sum=0, cout=0; internal
//   shift regs, carry, bit counter cleared. Takes effect immediately, mid-op too.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: start=1 at edge E0 -> load a,b into shift regs, carry=0, cnt=0, go RUN.
//   start=0 -> stay. sum/cout hold last result.
//  RUN: each edge: s=a_sh[0]^b_sh[0]^c; c<=maj(a_sh[0],b_sh[0],c);
//   a_sh,b_sh shift right; s shifted into MSB of acc (acc shifts right); cnt+1.
//   On edge E(WIDTH) (cnt==WIDTH-1): sum<=final acc incl. this bit,
//   cout<=final carry, go DONE.
//  DONE: done=1 for exactly this one cycle; next edge -> IDLE.
//  Latency: start sampled at E0 -> done high in cycle after E(WIDTH);
//   WIDTH+1 cycles start-to-done; next start can be accepted at E(WIDTH+2).
//  start while RUN or DONE: ignored, no effect on operands or result.
//  a/b changes after E0: no effect (operands captured).
//  sum/cout change only at E(WIDTH) of an operation; stable otherwise,
//   including through DONE and subsequent IDLE.
//  Overflow: sum wraps mod 2^WIDTH; cout=1 iff a+b >= 2^WIDTH.
//  Reset during RUN: operation aborted, no done pulse, sum/cout=0.
//  busy and done are registered (decoded from state reg), no comb paths
//   from inputs to outputs.
// TESTING
//  1. WIDTH=8, a=8'h35,b=8'h4A, start 1 cycle -> busy 1 after E0, done pulse
//     after E8, sum=8'h7F, cout=0, busy=0 after E9.
//  2. a=8'hFF,b=8'h01 -> sum=8'h00, cout=1; a=8'hFF,b=8'hFF -> sum=8'hFE, cout=1.
//  3. a=0,b=0 -> sum=0,cout=0, done still pulses exactly once after E8.
//  4. start held high continuously with a=8'h10,b=8'h20 then a changed to
//     8'hAA during RUN -> sum=8'h30; next op accepted at E10, no start
//     accepted during RUN/DONE; done pulses exactly once per op.
//  5. rst_n=0 asynchronously mid-RUN (after E4) -> busy,done,sum,cout=0
//     immediately; no done pulse; fresh start after release works (8'h01+8'h02=8'h03).
//  6. Random sweep 1000 operand pairs vs reference {cout,sum}=a+b; check
//     sum/cout stable between done pulses.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell plus a carry flop, LSB first.
// Result and carry-out are registered and held until the next operation completes.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               s_bit;
  logic               c_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  // The single full-adder cell shared by every bit position.
  assign s_bit  = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_next = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        acc_d   = {s_bit, acc_q[WIDTH-1:1]};
        carry_d = c_next;
        cnt_d   = cnt_q + CNT_W'(1);
        // Last bit: publish the accumulator including the bit formed this cycle.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = {s_bit, acc_q[WIDTH-1:1]};
          cout_d  = c_next;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder (WIDTH=8): latency, result,
// done pulse width, operand capture, start filtering and asynchronous reset.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_sum  = 8'h00;
  logic       last_cout = 1'b0;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One operation: start for one cycle at E0, then wait for done.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input string name);
    logic [8:0] exp9;
    int n;
    exp9  = {1'b0, av} + {1'b0, bv};
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_E0 got=%b want=1", name, busy);
    end
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      checks++;
      if (sum !== last_sum || cout !== last_cout) begin
        errors++;
        $display("FAIL %s hold got=%h/%b want=%h/%b", name, sum, cout, last_sum, last_cout);
      end
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL %s latency got=%0d want=8", name, n);
    end
    checks++;
    if (sum !== exp9[7:0] || cout !== exp9[8]) begin
      errors++;
      $display("FAIL %s result got=%h/%b want=%h/%b", name, sum, cout, exp9[7:0], exp9[8]);
    end
    last_sum  = exp9[7:0];
    last_cout = exp9[8];
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done got done=%b busy=%b want 0/0", name, done, busy);
    end
    checks++;
    if (sum !== last_sum || cout !== last_cout) begin
      errors++;
      $display("FAIL %s hold_idle got=%h/%b want=%h/%b", name, sum, cout, last_sum, last_cout);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b sum=%h cout=%b want 0/0/00/0", busy, done, sum, cout);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start busy got=%b want=0", busy);
    end
    last_sum  = 8'h00;
    last_cout = 1'b0;
  endtask

  task automatic test_basic;
    run_op(8'h35, 8'h4A, "basic_35_4A");
  endtask

  task automatic test_overflow;
    run_op(8'hFF, 8'h01, "ovf_FF_01");
    run_op(8'hFF, 8'hFF, "ovf_FF_FF");
    run_op(8'h80, 8'h80, "ovf_80_80");
  endtask

  task automatic test_zero;
    run_op(8'h00, 8'h00, "zero");
  endtask

  // start held high, a changed during RUN; next accept must be at E10.
  task automatic test_back_to_back;
    int n;
    int pulses;
    a = 8'h10;
    b = 8'h20;
    start = 1'b1;
    @(posedge clk); #1;
    a = 8'hAA;
    n = 0;
    pulses = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    pulses += (done === 1'b1) ? 1 : 0;
    checks++;
    if (n !== 8 || sum !== 8'h30 || cout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got lat=%0d sum=%h cout=%b want 8/30/0", n, sum, cout);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_not_accepted_in_done busy got=%b want=0", busy);
    end
    a = 8'h01;
    b = 8'h01;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept_E10 busy got=%b want=1", busy);
    end
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    pulses += (done === 1'b1) ? 1 : 0;
    checks++;
    if (n !== 8 || sum !== 8'h02 || cout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second got lat=%0d sum=%h cout=%b want 8/02/0", n, sum, cout);
    end
    repeat (3) begin
      @(posedge clk); #1;
      pulses += (done === 1'b1) ? 1 : 0;
    end
    checks++;
    if (pulses !== 2) begin
      errors++;
      $display("FAIL b2b_pulse_count got=%0d want=2", pulses);
    end
    last_sum  = 8'h02;
    last_cout = 1'b0;
  endtask

  task automatic test_async_reset;
    int pulses;
    a = 8'hC3;
    b = 8'h77;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got busy=%b done=%b sum=%h cout=%b want 0/0/00/0", busy, done, sum, cout);
    end
    pulses = 0;
    repeat (2) begin
      @(posedge clk); #1;
      pulses += (done === 1'b1) ? 1 : 0;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      pulses += (done === 1'b1) ? 1 : 0;
    end
    checks++;
    if (pulses !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_no_done got pulses=%0d busy=%b want 0/0", pulses, busy);
    end
    last_sum  = 8'h00;
    last_cout = 1'b0;
    run_op(8'h01, 8'h02, "after_reset_01_02");
  endtask

  task automatic test_random;
    for (int i = 0; i < 1000; i++) begin
      run_op(8'($urandom_range(255)), 8'($urandom_range(255)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_zero();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
